// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, alu_op encodings, control-bit layout.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents:
//   XLEN, NREG        datapath width and architectural register count
//   OPC_*             major opcodes handled by the decoder
//   ALU_OP_*          2-bit alu_op encodings carried in the control word
//   CTRL_*            bit positions inside the 9-bit control word
//   fmt_t, imm_gen    instruction format tag and the sign-extended immediate it selects
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  // Control word layout: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[1:0]}
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_ALU_OP_MSB = 1;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X   // unsupported opcode
  } fmt_t;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst, input fmt_t fmt);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2 async read ports, 1 write port, x0 hardwired to zero.
// Latency: reads combinational; writes commit on the rising edge.
// Backpressure: none; a write is always accepted.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset (clears every register)
//   raddr1/raddr2 -> rdata1/rdata2   read ports, write-first bypass from the write port
//   we, waddr, wdata        write port; writes to x0 are discarded
module reg_file
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  // x0 has no storage.
  logic [XLEN-1:0] regs [1:NREG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-first: a same-cycle write to the register being read is forwarded,
  // so WB and ID can share a cycle without a separate forwarding path.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) begin
      rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) begin
      rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage plus ID/EX pipeline register, with load-use hazard detection.
// Latency: 1 cycle from IF/ID contents to ex_* outputs.
// Backpressure: stall_o holds PC and IF/ID for one cycle on a load-use hazard; flush_i wins and forces a bubble.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pc_ifid_i, inst_ifid_i, pc4_ifid_i   instruction being decoded
//   flush_i                          kill the instruction in ID (bubble into EX)
//   wb_we_i, wb_rd_i, wb_data_i      register write-back from WB
//   stall_o                          combinational load-use stall request
//   illegal_o, ex_*                  registered decode results for EX
module id_ex_stage
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_ifid_i,
  input  logic [31:0]       inst_ifid_i,
  input  logic [XLEN-1:0]   pc4_ifid_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              stall_o,
  output logic              illegal_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_pc4_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [2:0]        ex_funct3_o,
  output logic              ex_funct7b5_o,
  output logic [CTRL_W-1:0] ex_ctrl_o
);

  logic [6:0]        opcode;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [CTRL_W-1:0] ctrl;
  logic              illegal;
  logic              is_lui;
  fmt_t              fmt;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              load_use;
  logic              bubble;

  assign opcode = inst_ifid_i[6:0];
  assign rd     = inst_ifid_i[11:7];
  assign rs1    = inst_ifid_i[19:15];
  assign rs2    = inst_ifid_i[24:20];

  reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_we_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i)
  );

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_lui  = 1'b0;
    fmt     = FMT_X;
    case (opcode)
      OPC_LOAD: begin
        fmt                                     = FMT_I;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_MEM_READ]                     = 1'b1;
        ctrl[CTRL_MEM_TO_REG]                   = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      OPC_OP_IMM: begin
        fmt                                     = FMT_I;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ITYPE;
      end
      OPC_AUIPC: begin
        fmt                                     = FMT_U;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      OPC_STORE: begin
        fmt                                     = FMT_S;
        ctrl[CTRL_MEM_WRITE]                    = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      OPC_OP: begin
        fmt                                     = FMT_R;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_RTYPE;
      end
      OPC_LUI: begin
        // Executed as 0 + imm, so the rs1 operand is zeroed below.
        fmt                                     = FMT_U;
        is_lui                                  = 1'b1;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      OPC_BRANCH: begin
        fmt                                     = FMT_B;
        ctrl[CTRL_BRANCH]                       = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_BRANCH;
      end
      OPC_JALR: begin
        fmt                                     = FMT_I;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_JUMP]                         = 1'b1;
        ctrl[CTRL_ALU_SRC]                      = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      OPC_JAL: begin
        fmt                                     = FMT_J;
        ctrl[CTRL_REG_WRITE]                    = 1'b1;
        ctrl[CTRL_JUMP]                         = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]   = ALU_OP_ADD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  // A load in EX whose result this instruction needs cannot be forwarded in
  // time; one bubble lets it reach MEM/WB forwarding. x0 never creates a hazard.
  assign load_use = ex_ctrl_o[CTRL_MEM_READ] && (ex_rd_o != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd_o) || (uses_rs2 && rs2 == ex_rd_o));

  // A flush discards the instruction in ID, so stalling it would be pointless.
  assign stall_o = load_use && !flush_i;
  assign bubble  = flush_i || stall_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_o     <= 1'b0;
      ex_pc_o       <= '0;
      ex_pc4_o      <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_funct3_o   <= '0;
      ex_funct7b5_o <= 1'b0;
      ex_ctrl_o     <= '0;
    end else begin
      ex_pc_o       <= pc_ifid_i;
      ex_pc4_o      <= pc4_ifid_i;
      // LUI also clears the rs1 index so forwarding never overrides the zero.
      ex_rs1_data_o <= is_lui ? '0 : rs1_data;
      ex_rs1_o      <= is_lui ? 5'd0 : rs1;
      ex_rs2_data_o <= rs2_data;
      ex_rs2_o      <= rs2;
      ex_imm_o      <= imm_gen(inst_ifid_i, fmt);
      ex_rd_o       <= rd;
      ex_funct3_o   <= inst_ifid_i[14:12];
      ex_funct7b5_o <= inst_ifid_i[30];
      if (bubble) begin
        ex_ctrl_o <= '0;
        illegal_o <= 1'b0;
      end else begin
        ex_ctrl_o <= ctrl;
        illegal_o <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: inputs driven on the falling edge, outputs sampled on the falling edge.
// Latency: each step is one rising edge.
// Backpressure: the bench models IF/ID hold by keeping inst_ifid_i unchanged across a stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_ifid_i;
  logic [31:0] inst_ifid_i;
  logic [31:0] pc4_ifid_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic        illegal_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_pc4_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o;
  logic [8:0]  ex_ctrl_o;

  int checks;
  int failures;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_ifid_i     (pc_ifid_i),
    .inst_ifid_i   (inst_ifid_i),
    .pc4_ifid_i    (pc4_ifid_i),
    .flush_i       (flush_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .stall_o       (stall_o),
    .illegal_o     (illegal_o),
    .ex_pc_o       (ex_pc_o),
    .ex_pc4_o      (ex_pc4_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rs1_o      (ex_rs1_o),
    .ex_rs2_o      (ex_rs2_o),
    .ex_rd_o       (ex_rd_o),
    .ex_funct3_o   (ex_funct3_o),
    .ex_funct7b5_o (ex_funct7b5_o),
    .ex_ctrl_o     (ex_ctrl_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Control words: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op}
  localparam logic [8:0] C_ADDI   = 9'b1_0001_0011; // 0x113
  localparam logic [8:0] C_STORE  = 9'b0_0101_0000; // 0x050
  localparam logic [8:0] C_RTYPE  = 9'b1_0000_0010; // 0x102
  localparam logic [8:0] C_LOAD   = 9'b1_1011_0000; // 0x1B0
  localparam logic [8:0] C_BRANCH = 9'b0_0000_1001; // 0x009

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    pc_ifid_i   = 32'h0;
    pc4_ifid_i  = 32'h4;
    inst_ifid_i = 32'h00000013;
    flush_i     = 1'b0;
    wb_we_i     = 1'b0;
    wb_rd_i     = 5'd0;
    wb_data_i   = 32'h0;

    // Reset
    step();
    step();
    chk("rst_ctrl", {23'd0, ex_ctrl_o}, 32'h0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'h0);
    chk("rst_pc", ex_pc_o, 32'h0);
    chk("rst_imm", ex_imm_o, 32'h0);
    chk("rst_rd", {27'd0, ex_rd_o}, 32'h0);
    chk("rst_stall", {31'd0, stall_o}, 32'h0);
    rst = 1'b0;

    // add x8,x5,x5: x5 reads zero after reset
    inst_ifid_i = 32'h00528433; pc_ifid_i = 32'h100; pc4_ifid_i = 32'h104;
    step();
    chk("x5_rs1_data", ex_rs1_data_o, 32'h0);
    chk("x5_rs2_data", ex_rs2_data_o, 32'h0);
    chk("x5_rs1_idx", {27'd0, ex_rs1_o}, 32'd5);
    chk("x5_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_RTYPE});

    // Preload x1=0x100, x2=0x22 through WB
    inst_ifid_i = 32'h00000013;
    wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h100;
    step();
    wb_rd_i = 5'd2; wb_data_i = 32'h22;
    step();
    wb_we_i = 1'b0;

    // addi x1,x0,5
    inst_ifid_i = 32'h00500093; pc_ifid_i = 32'h1000; pc4_ifid_i = 32'h1004;
    step();
    chk("addi_imm", ex_imm_o, 32'd5);
    chk("addi_rd", {27'd0, ex_rd_o}, 32'd1);
    chk("addi_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_ADDI});
    chk("addi_pc", ex_pc_o, 32'h1000);
    chk("addi_pc4", ex_pc4_o, 32'h1004);

    // sw x1,-4(x2)
    inst_ifid_i = 32'hFE112E23;
    step();
    chk("sw_imm", ex_imm_o, 32'hFFFFFFFC);
    chk("sw_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_STORE});
    chk("sw_rs1_data", ex_rs1_data_o, 32'h22);
    chk("sw_rs2_data", ex_rs2_data_o, 32'h100);
    chk("sw_funct3", {29'd0, ex_funct3_o}, 32'd2);

    // add x4,x3,x0 with same-cycle WB of x3
    inst_ifid_i = 32'h00018233;
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
    step();
    chk("bypass_rs1_data", ex_rs1_data_o, 32'hDEADBEEF);
    wb_we_i = 1'b0;
    step();
    chk("stored_rs1_data", ex_rs1_data_o, 32'hDEADBEEF);

    // WB to x0 is dropped, bypass included
    inst_ifid_i = 32'h00000233;
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234;
    step();
    chk("x0_bypass", ex_rs1_data_o, 32'h0);
    wb_we_i = 1'b0;
    step();
    chk("x0_later", ex_rs1_data_o, 32'h0);

    // lw x6,0(x1) then add x7,x6,x2
    inst_ifid_i = 32'h0000A303;
    step();
    chk("lw_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_LOAD});
    chk("lw_rd", {27'd0, ex_rd_o}, 32'd6);
    inst_ifid_i = 32'h002303B3;
    #1;
    chk("lu_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("lu_bubble", {23'd0, ex_ctrl_o}, 32'h0);
    chk("lu_stall_once", {31'd0, stall_o}, 32'd0);
    step();
    chk("lu_issue_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_RTYPE});
    chk("lu_issue_rd", {27'd0, ex_rd_o}, 32'd7);
    chk("lu_issue_rs1", {27'd0, ex_rs1_o}, 32'd6);
    chk("lu_issue_rs2_data", ex_rs2_data_o, 32'h22);

    // sub x9,x1,x2
    inst_ifid_i = 32'h402084B3;
    step();
    chk("sub_f7b5", {31'd0, ex_funct7b5_o}, 32'd1);
    chk("sub_rs1_data", ex_rs1_data_o, 32'h100);

    // lw x0 never stalls
    inst_ifid_i = 32'h0000A003;
    step();
    inst_ifid_i = 32'h002003B3;
    #1;
    chk("lw_x0_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("lw_x0_next_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_RTYPE});

    // beq x1,x2,+8 normally, then flushed
    inst_ifid_i = 32'h00208463;
    step();
    chk("beq_imm", ex_imm_o, 32'd8);
    chk("beq_ctrl", {23'd0, ex_ctrl_o}, {23'd0, C_BRANCH});
    flush_i = 1'b1;
    step();
    chk("flush_ctrl", {23'd0, ex_ctrl_o}, 32'h0);
    flush_i = 1'b0;

    // jal x1,+0x800
    inst_ifid_i = 32'h001000EF;
    step();
    chk("jal_imm", ex_imm_o, 32'h800);

    // lui x5,0x12345 while x8 (its rs1 field) is being written
    inst_ifid_i = 32'h123452B7;
    wb_we_i = 1'b1; wb_rd_i = 5'd8; wb_data_i = 32'hAAAA;
    step();
    chk("lui_imm", ex_imm_o, 32'h12345000);
    chk("lui_rs1_data", ex_rs1_data_o, 32'h0);
    wb_we_i = 1'b0;

    // Flush during a load-use stall
    inst_ifid_i = 32'h0000A303;
    step();
    inst_ifid_i = 32'h002303B3;
    flush_i = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("flush_lu_ctrl", {23'd0, ex_ctrl_o}, 32'h0);
    flush_i = 1'b0;

    // Unsupported opcode
    inst_ifid_i = 32'h0000007F;
    step();
    chk("ill_flag", {31'd0, illegal_o}, 32'd1);
    chk("ill_ctrl", {23'd0, ex_ctrl_o}, 32'h0);

    // Reset mid-stream
    inst_ifid_i = 32'h00500093; pc_ifid_i = 32'h2000;
    rst = 1'b1;
    step();
    chk("mrst_ctrl", {23'd0, ex_ctrl_o}, 32'h0);
    chk("mrst_illegal", {31'd0, illegal_o}, 32'd0);
    chk("mrst_imm", ex_imm_o, 32'h0);
    chk("mrst_rd", {27'd0, ex_rd_o}, 32'h0);
    chk("mrst_pc", ex_pc_o, 32'h0);
    rst = 1'b0;
    inst_ifid_i = 32'h00008233;   // add x4,x1,x0: x1 was cleared
    step();
    chk("mrst_x1_cleared", ex_rs1_data_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
